// File: rtl/npu_pkg.sv
// Shared constants and configuration type for the PE requantization stage.
// All datapath widths are fixed here so every file agrees on them.
package npu_pkg;

  localparam int ACC_WIDTH   = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int SCALE_WIDTH = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int CNT_WIDTH   = 16;

  localparam int SUM_WIDTH  = ACC_WIDTH + 1;
  localparam int PROD_WIDTH = SUM_WIDTH + SCALE_WIDTH;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef struct packed {
    logic signed [ACC_WIDTH-1:0]  bias;
    logic        [SCALE_WIDTH-1:0] scale;
    logic        [SHIFT_WIDTH-1:0] shift;
    logic signed [DATA_WIDTH-1:0] zp;
    logic                         relu;
  } requant_cfg_t;

  localparam requant_cfg_t CFG_RESET = '{
    bias:  '0,
    scale: SCALE_WIDTH'(1),
    shift: '0,
    zp:    '0,
    relu:  1'b0
  };

endpackage

// File: rtl/npu_pipe_reg.sv
// One pipeline slot: valid/data register that loads whenever it is empty or
// its contents move on, so bubbles collapse and stalls hold data stable.
module npu_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign ready = !valid || next_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/pe_requant.sv
// Requantizes signed accumulator results to int8: bias, scale, rounding shift,
// zero point, optional ReLU and saturation, in a 3-stage valid/ready pipeline.
module pe_requant
  import npu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   cfg_load,
  input  logic [ACC_WIDTH-1:0]   cfg_bias,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [DATA_WIDTH-1:0]  cfg_zp,
  input  logic                   cfg_relu,
  output logic                   cfg_ack,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   sat_count,
  input  logic                   cnt_clr
);

  localparam int VW = PROD_WIDTH + 2;
  localparam logic signed [VW-1:0]         V_MAX   = VW'(INT8_MAX);
  localparam logic signed [VW-1:0]         V_MIN   = VW'(INT8_MIN);
  localparam logic signed [PROD_WIDTH:0]   RND_ONE = (PROD_WIDTH + 1)'(1);

  requant_cfg_t cfg_reg;
  logic cfg_ack_reg;
  logic cfg_apply;
  logic [CNT_WIDTH-1:0] sat_count_reg;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic [SUM_WIDTH-1:0]  sum_next, s1_sum;
  logic [PROD_WIDTH-1:0] prod_next, s2_prod;
  logic [DATA_WIDTH:0]   res_next, s3_res;

  logic signed [PROD_WIDTH-1:0] sum_ext, scale_ext;
  logic signed [PROD_WIDTH:0]   prod_ext, rnd, biased, rounded;
  logic signed [VW-1:0]         v, zp_ext;

  assign busy      = s1_valid || s2_valid || s3_valid;
  // Config only changes with the pipe empty, so in-flight beats never see it move.
  assign cfg_apply = cfg_load && !busy && !cfg_ack_reg;
  assign in_ready  = s1_ready && !cfg_apply;

  assign sum_next  = {acc_in[ACC_WIDTH-1], acc_in} + {cfg_reg.bias[ACC_WIDTH-1], cfg_reg.bias};
  assign sum_ext   = {{SCALE_WIDTH{s1_sum[SUM_WIDTH-1]}}, s1_sum};
  assign scale_ext = {{SUM_WIDTH{1'b0}}, cfg_reg.scale};
  assign prod_next = sum_ext * scale_ext;

  always_comb begin
    prod_ext = {s2_prod[PROD_WIDTH-1], s2_prod};
    rnd      = '0;
    if (cfg_reg.shift != '0) rnd = RND_ONE << (cfg_reg.shift - SHIFT_WIDTH'(1));
    biased   = prod_ext + rnd;
    rounded  = biased >>> cfg_reg.shift;
    zp_ext   = {{(VW - DATA_WIDTH){cfg_reg.zp[DATA_WIDTH-1]}}, cfg_reg.zp};
    v        = {rounded[PROD_WIDTH], rounded} + zp_ext;
    if (cfg_reg.relu && (v < zp_ext)) v = zp_ext;
    // Top bit of the stage-3 word flags a clipped result for the counter.
    if (v > V_MAX)      res_next = {1'b1, V_MAX[DATA_WIDTH-1:0]};
    else if (v < V_MIN) res_next = {1'b1, V_MIN[DATA_WIDTH-1:0]};
    else                res_next = {1'b0, v[DATA_WIDTH-1:0]};
  end

  npu_pipe_reg #(.WIDTH(SUM_WIDTH)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && in_ready), .in_data(sum_next),
    .next_ready(s2_ready), .ready(s1_ready), .valid(s1_valid), .data(s1_sum)
  );

  npu_pipe_reg #(.WIDTH(PROD_WIDTH)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_valid), .in_data(prod_next),
    .next_ready(s3_ready), .ready(s2_ready), .valid(s2_valid), .data(s2_prod)
  );

  npu_pipe_reg #(.WIDTH(DATA_WIDTH + 1)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2_valid), .in_data(res_next),
    .next_ready(out_ready), .ready(s3_ready), .valid(s3_valid), .data(s3_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg     <= CFG_RESET;
      cfg_ack_reg <= 1'b0;
    end else begin
      cfg_ack_reg <= cfg_apply;
      if (cfg_apply) begin
        cfg_reg <= '{bias: cfg_bias, scale: cfg_scale, shift: cfg_shift,
                     zp: cfg_zp, relu: cfg_relu};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_reg <= '0;
    end else if (cnt_clr) begin
      sat_count_reg <= '0;
    end else if (s3_valid && out_ready && s3_res[DATA_WIDTH] && (sat_count_reg != '1)) begin
      sat_count_reg <= sat_count_reg + 1'b1;
    end
  end

  assign out_valid = s3_valid;
  assign data_out  = s3_res[DATA_WIDTH-1:0];
  assign cfg_ack   = cfg_ack_reg;
  assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_pe_requant.sv
// Self-checking bench for pe_requant: directed scenarios plus randomized
// streams scored against an arithmetic reference model.
module tb_pe_requant;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  data_out;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_bias = '0;
  logic [15:0] cfg_scale = 16'd1;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic        cfg_relu = 1'b0;
  logic        cfg_ack;
  logic        busy;
  logic [15:0] sat_count;
  logic        cnt_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  longint m_bias = 0, m_scale = 1, m_shift = 0, m_zp = 0;
  bit     m_relu = 1'b0;

  pe_requant dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .cfg_load(cfg_load), .cfg_bias(cfg_bias),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .cfg_relu(cfg_relu), .cfg_ack(cfg_ack), .busy(busy),
    .sat_count(sat_count), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, floor division for the rounding shift.
  function automatic void model(input longint acc, output logic [7:0] res, output bit sat);
    longint sum, prod, num, p2, q, v;
    sum = acc + m_bias;
    prod = sum * m_scale;
    p2 = 1;
    for (int i = 0; i < m_shift; i++) p2 = p2 * 2;
    num = prod + ((m_shift > 0) ? p2 / 2 : 0);
    q = num / p2;
    if ((num % p2) != 0 && num < 0) q = q - 1;
    v = q + m_zp;
    if (m_relu && v < m_zp) v = m_zp;
    sat = 1'b0;
    if (v > 127) begin v = 127; sat = 1'b1; end
    else if (v < -128) begin v = -128; sat = 1'b1; end
    res = 8'(v);
  endfunction

  task automatic load_cfg(input int bias, input int scale, input int shift, input int zp, input bit relu);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_bias = 32'(bias); cfg_scale = 16'(scale); cfg_shift = 5'(shift);
    cfg_zp = 8'(zp); cfg_relu = relu; cfg_load = 1'b1;
    n = 0;
    #1;
    while (!cfg_ack && n < 60) begin @(negedge clk); #1; n++; end
    checks++;
    if (!cfg_ack) begin failures++; $display("FAIL cfg_ack_timeout: got no ack after %0d cycles, required ack", n); end
    cfg_load = 1'b0;
    m_bias = bias; m_scale = scale; m_shift = shift; m_zp = zp; m_relu = relu;
  endtask

  // Drives one beat and returns the result plus cycles from accept to out_valid.
  task automatic send_recv(input int acc, output logic [7:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; acc_in = 32'(acc); out_ready = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    res = data_out;
    $display("beat acc=%0d out=%0d latency=%0d", acc, $signed(res), lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (data_out !== 8'd0) begin failures++; $display("FAIL reset_data_out: got %0d required 0", data_out); end
    checks++; if (cfg_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ack_busy: got ack=%b busy=%b required 0 0", cfg_ack, busy); end
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL reset_sat_count: got %0d required 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int accs[3] = '{35, 25, -21};
    logic [7:0] r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_recv(accs[i], r, lat);
      checks++; if (r !== 8'(accs[i])) begin failures++; $display("FAIL identity_value: got %0d required %0d", $signed(r), accs[i]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL identity_latency: got %0d required 3", lat); end
    end
  endtask

  task automatic test_scale_round();
    logic [7:0] r;
    int lat;
    load_cfg(0, 3, 1, 0, 0);
    send_recv(25, r, lat);
    checks++; if (r !== 8'd38) begin failures++; $display("FAIL scale3_shift1: got %0d required 38", $signed(r)); end
    load_cfg(0, 1, 3, 0, 0);
    send_recv(20, r, lat);
    checks++; if (r !== 8'd3) begin failures++; $display("FAIL round_pos: got %0d required 3", $signed(r)); end
    send_recv(-20, r, lat);
    checks++; if (r !== 8'hFE) begin failures++; $display("FAIL round_neg: got %0d required -2", $signed(r)); end
  endtask

  task automatic test_saturation();
    logic [7:0] r;
    int lat, n;
    load_cfg(24, 1, 3, 0, 0);
    send_recv(1000, r, lat);
    checks++; if (r !== 8'd127) begin failures++; $display("FAIL sat_high: got %0d required 127", $signed(r)); end
    @(negedge clk); #1;
    checks++; if (sat_count !== 16'd1) begin failures++; $display("FAIL sat_count_1: got %0d required 1", sat_count); end
    send_recv(-2000, r, lat);
    checks++; if (r !== 8'h80) begin failures++; $display("FAIL sat_low: got %0d required -128", $signed(r)); end
    @(negedge clk); #1;
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count_2: got %0d required 2", sat_count); end
    // Third saturating beat is held at the output so cnt_clr lands on its handshake.
    out_ready = 1'b0;
    in_valid = 1'b1; acc_in = 32'd1000;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    #1;
    while (!out_valid && n < 50) begin @(negedge clk); #1; n++; end
    checks++; if (data_out !== 8'd127) begin failures++; $display("FAIL sat_third: got %0d required 127", $signed(data_out)); end
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL clr_priority: got %0d required 0", sat_count); end
    $display("saturation done sat_count=%0d", sat_count);
  endtask

  task automatic test_relu_zp();
    logic [7:0] r;
    int lat;
    load_cfg(0, 1, 0, 0, 1);
    send_recv(-21, r, lat);
    checks++; if (r !== 8'd0) begin failures++; $display("FAIL relu_zp0: got %0d required 0", $signed(r)); end
    load_cfg(0, 1, 0, -5, 1);
    send_recv(-21, r, lat);
    checks++; if (r !== 8'hFB) begin failures++; $display("FAIL relu_zpm5: got %0d required -5", $signed(r)); end
    load_cfg(0, 1, 0, -5, 0);
    send_recv(10, r, lat);
    checks++; if (r !== 8'd5) begin failures++; $display("FAIL zp_norelu: got %0d required 5", $signed(r)); end
  endtask

  task automatic test_backpressure();
    int nxt = 1, got = 0, c = 0;
    int rx[6], rxc[6];
    load_cfg(0, 1, 0, 0, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = (nxt <= 6); acc_in = 32'(nxt);
      #1;
      if (in_valid && in_ready) nxt++;
    end
    @(negedge clk); #1;
    checks++; if (nxt - 1 !== 3) begin failures++; $display("FAIL bp_accepted: got %0d required 3", nxt - 1); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    out_ready = 1'b1;
    #1;
    while (got < 6 && c < 40) begin
      if (out_valid) begin rx[got] = $signed(data_out); rxc[got] = c; got++; end
      if (in_valid && in_ready) nxt++;
      @(negedge clk);
      in_valid = (nxt <= 6); acc_in = 32'(nxt);
      #1;
      c++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 6) begin failures++; $display("FAIL bp_count: got %0d required 6", got); end
    for (int i = 0; i < got; i++) begin
      $display("bp out[%0d]=%0d cycle=%0d", i, rx[i], rxc[i]);
      checks++; if (rx[i] !== i + 1) begin failures++; $display("FAIL bp_order: got %0d required %0d", rx[i], i + 1); end
      if (i > 0) begin
        checks++; if (rxc[i] !== rxc[i-1] + 1) begin failures++; $display("FAIL bp_gap: got cycle %0d required %0d", rxc[i], rxc[i-1] + 1); end
      end
    end
  endtask

  task automatic test_config_handshake();
    int got = 0, c = 0, ack_got = -1;
    int rx[4];
    bit prev_busy = 1'b1, prev_ir = 1'b1, ack_busy = 1'b1, ack_ir = 1'b1, seen = 1'b0;
    logic [7:0] r;
    int lat;
    load_cfg(0, 1, 0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; acc_in = 32'd10;
    @(negedge clk); acc_in = 32'd11;
    @(negedge clk); in_valid = 1'b0;
    cfg_scale = 16'd2; cfg_load = 1'b1;
    #1;
    while (!seen && c < 30) begin
      if (out_valid && got < 4) begin rx[got] = $signed(data_out); got++; end
      if (cfg_ack) begin seen = 1'b1; ack_got = got; ack_busy = prev_busy; ack_ir = prev_ir; cfg_load = 1'b0; end
      prev_busy = busy; prev_ir = in_ready;
      @(negedge clk); #1; c++;
    end
    cfg_load = 1'b0;
    m_scale = 2;
    checks++; if (!seen) begin failures++; $display("FAIL cfg_ack_seen: got none required pulse"); end
    checks++; if (ack_got !== 2) begin failures++; $display("FAIL cfg_old_beats: got %0d outputs before ack required 2", ack_got); end
    checks++; if (got >= 2 && (rx[0] !== 10 || rx[1] !== 11)) begin failures++; $display("FAIL cfg_old_scale: got %0d,%0d required 10,11", rx[0], rx[1]); end
    checks++; if (ack_busy !== 1'b0 || ack_ir !== 1'b0) begin failures++; $display("FAIL cfg_apply_cycle: got busy=%b in_ready=%b required 0 0", ack_busy, ack_ir); end
    send_recv(7, r, lat);
    checks++; if (r !== 8'd14) begin failures++; $display("FAIL cfg_new_scale: got %0d required 14", $signed(r)); end
  endtask

  task automatic test_reset_midflight();
    int seen_out = 0;
    logic [7:0] r;
    int lat;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b1; acc_in = 32'(k + 50);
    end
    @(negedge clk); in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_drop: got out_valid=%b busy=%b required 0 0", out_valid, busy); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    m_bias = 0; m_scale = 1; m_shift = 0; m_zp = 0; m_relu = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); #1; if (out_valid) seen_out++; end
    checks++; if (seen_out !== 0) begin failures++; $display("FAIL midreset_ghost: got %0d outputs required 0", seen_out); end
    send_recv(35, r, lat);
    checks++; if (r !== 8'd35) begin failures++; $display("FAIL midreset_cfg_default: got %0d required 35", $signed(r)); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] er, mr;
    bit ms;
    int sent, got, cyc, clipped, a, nb;
    bit holding;
    for (int cfgi = 0; cfgi < 3; cfgi++) begin
      load_cfg(int'($urandom_range(0, 2000)) - 1000,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(1, 300)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      @(negedge clk); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      exp_q.delete();
      sent = 0; got = 0; cyc = 0; clipped = 0; holding = 1'b0; nb = 40;
      while (got < nb && cyc < 2000) begin
        @(negedge clk);
        if (!holding) begin
          in_valid = (sent < nb) && ($urandom_range(0, 3) != 0);
          a = $urandom;
          acc_in = 32'(a >>> $urandom_range(0, 31));
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
          er = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (data_out !== er) begin failures++; $display("FAIL random_data: got %0d required %0d", $signed(data_out), $signed(er)); end
          got++;
        end
        if (in_valid && in_ready) begin
          model(longint'($signed(acc_in)), mr, ms);
          exp_q.push_back(mr);
          if (ms) clipped++;
          sent++;
        end
        holding = in_valid && !in_ready;
        cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (got !== nb) begin failures++; $display("FAIL random_count: got %0d required %0d", got, nb); end
      checks++; if (sat_count !== 16'(clipped)) begin failures++; $display("FAIL random_sat_count: got %0d required %0d", sat_count, clipped); end
      $display("random cfg %0d: bias=%0d scale=%0d shift=%0d zp=%0d relu=%0d beats=%0d clipped=%0d",
               cfgi, m_bias, m_scale, m_shift, m_zp, m_relu, got, clipped);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scale_round();
    test_saturation();
    test_relu_zp();
    test_backpressure();
    test_config_handshake();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_requant.md
Name: pe_requant

Overview:
- Post-processing stage directly downstream of the PE array accumulator output.
- Takes signed 32-bit accumulator results and applies, in order: bias add, fixed-point scale multiply, rounding right shift, zero-point add, optional ReLU, and int8 saturation.
- 3-stage pipeline, valid/ready on both sides, full throughput of 1 beat/cycle.
- Per-block configuration register with a safe-update handshake, plus a saturation event counter.

Parameters:
- ACC_WIDTH, 32, accumulator input width (signed)
- DATA_WIDTH, 8, output activation width (signed)
- SCALE_WIDTH, 16, unsigned multiplier width
- SHIFT_WIDTH, 5, right-shift amount width (0..31)
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  block can accept a beat
- acc_in  in  ACC_WIDTH  signed accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- data_out  out  DATA_WIDTH  signed requantized activation
- cfg_load  in  1  request to load configuration
- cfg_bias  in  ACC_WIDTH  signed bias
- cfg_scale  in  SCALE_WIDTH  unsigned multiplier
- cfg_shift  in  SHIFT_WIDTH  right-shift amount
- cfg_zp  in  DATA_WIDTH  signed output zero point
- cfg_relu  in  1  ReLU enable
- cfg_ack  out  1  one-cycle pulse: configuration applied
- busy  out  1  any pipeline stage holds a valid beat
- sat_count  out  CNT_WIDTH  number of saturated outputs
- cnt_clr  in  1  synchronous clear of sat_count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Outputs: out_valid=0, data_out=0, cfg_ack=0, busy=0, sat_count=0, in_ready=1.
  - Config registers: bias=0, scale=1, shift=0, zp=0, relu=0.
  - All stage valids cleared. Reset mid-operation drops in-flight beats; no partial output is produced.
- Handshake:
  - A beat transfers when valid && ready.
  - out_valid/data_out stay stable while out_ready=0.
  - in_ready is combinational: stage-1 empty, or stage 1 advancing this cycle.
- Pipeline flow:
  - Each stage advances when the next stage is empty or advancing, so bubbles collapse.
  - Latency is 3 cycles from input accept to out_valid when out_ready=1.
  - Capacity is 3 beats. Order is preserved and no beat is lost or duplicated.
- S1 (bias add): sum = acc_in + bias, computed at ACC_WIDTH+1 bits (33), no saturation.
- S2 (scale): prod = sum * scale, signed × unsigned, 49-bit signed, exact.
- S3 (round, offset, clamp):
  - r = (prod + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. This is arithmetic shift, rounding half toward +inf.
  - v = r + zp.
  - If relu: v = max(v, zp).
  - Saturate v to [-128, 127].
- Saturation counter:
  - sat_count increments by 1 on each output handshake whose value was clipped.
  - It holds at all-ones and does not wrap.
  - cnt_clr has priority over a simultaneous increment.
- Configuration update:
  - cfg_load is a level request, held by the requester until cfg_ack.
  - It is applied only in a cycle where busy=0 and no input is accepted. In that cycle in_ready is forced to 0.
  - Config registers update on that edge; cfg_ack pulses the following cycle.
  - Beats accepted before the load always complete with the old configuration.
- busy = OR of the three stage valids.

Decomposition:
- npu_pkg holds:
  - constants ACC_WIDTH, DATA_WIDTH, SCALE_WIDTH, SHIFT_WIDTH;
  - typedef requant_cfg_t, a packed struct {bias, scale, shift, zp, relu};
  - localparams INT8_MAX=127 and INT8_MIN=-128.
- One sub-module, npu_pipe_reg: a parameterised valid/data register with the advance/stall rule, instantiated 3 times.

Test Plan:
- Identity: cfg {0,1,0,0,0}, acc 35, 25, -21 -> out 35, 25, -21; out_valid exactly 3 cycles after each accept.
- Scale/round: cfg scale=3, shift=1; acc 25 -> 38. cfg scale=1, shift=3; acc 20 -> 3 and acc -20 -> -2.
- Saturation: bias=24, shift=3; acc 1000 -> 127 and sat_count=1. Then acc -2000 -> -128 and sat_count=2. cnt_clr in the same cycle as a third saturation -> sat_count=0.
- ReLU/zero point: relu=1, zp=0, acc -21 -> 0. relu=1, zp=-5, acc -21 -> -5. relu=0, zp=-5, acc 10 -> 5.
- Backpressure: stream 6 beats (1..6) with out_ready=0 for the first 8 cycles -> in_ready drops after 3 beats accepted. On release: outputs 1..6 in order, one per cycle, none missing.
- Config handshake and reset: assert cfg_load (scale=2) while 2 beats are in flight -> those beats use scale=1; cfg_ack occurs after busy=0; the next beat uses scale=2. Assert rst_n=0 with beats in flight -> out_valid=0 immediately, busy=0, no output after release.
